// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-side signals of the memory arbiter.
// slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
   parameter int unsigned NBITS = 8
);
   // fetch port
   logic             f_req;
   logic [NBITS-1:0] f_addr;
   logic             f_ack;
   logic [NBITS-1:0] f_rdata;
   // data port
   logic             d_req;
   logic             d_we;
   logic [NBITS-1:0] d_addr;
   logic [NBITS-1:0] d_wdata;
   logic             d_ack;
   logic [NBITS-1:0] d_rdata;
   // memory port
   logic             m_read;
   logic             m_write;
   logic [NBITS-1:0] m_addr;
   logic [NBITS-1:0] m_wdata;
   logic [NBITS-1:0] m_rdata;
   logic             busy;
   // status
   logic             stall;
   logic             err;

   modport slave (
      input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata, busy,
      output f_ack, f_rdata, d_ack, d_rdata, m_read, m_write, m_addr, m_wdata,
             stall, err
   );

   modport master (
      output f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata, busy,
      input  f_ack, f_rdata, d_ack, d_rdata, m_read, m_write, m_addr, m_wdata,
             stall, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between a fetch and a data requester.
// Fixed data-over-fetch priority by default; define MEM_ARB_RR_EN to make
// contention alternate between the two requesters.
// Acks are combinational in the completion cycle; a transaction that keeps
// busy high for TIMEOUT cycles is dropped and reported with a one-cycle err.
module mem_arbiter #(
   parameter int unsigned NBITS   = 8,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic          clock,
   input  logic          reset,
   mem_arbiter_if.slave  io_bus
);

   localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DATA  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             w_grant_d;
   logic             w_grant_f;
   logic             w_active;
   logic             w_done;
   logic             w_timeout;

   logic [NBITS-1:0] r_addr;
   logic             r_we;
   logic [NBITS-1:0] r_wdata;
   logic [CW-1:0]    r_cnt;
   logic [NBITS-1:0] r_f_rdata;
   logic [NBITS-1:0] r_d_rdata;
   logic             r_err;

   logic             w_m_read;
   logic             w_m_write;
   logic [NBITS-1:0] w_m_addr;
   logic [NBITS-1:0] w_m_wdata;
   logic             w_f_ack;
   logic             w_d_ack;
   logic             w_stall;

`ifdef MEM_ARB_RR_EN
   logic             r_last_f;
`endif

   assign w_active  = (r_state != S_IDLE);
   assign w_done    = w_active && !io_bus.busy && !reset;
   assign w_timeout = w_active && io_bus.busy && (r_cnt == CW'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state and grant decision
   always_comb begin
      w_next    = r_state;
      w_grant_d = 1'b0;
      w_grant_f = 1'b0;
      case (r_state)
         S_IDLE: begin
`ifdef MEM_ARB_RR_EN
            if (io_bus.d_req && io_bus.f_req) begin
               w_grant_d = r_last_f;
               w_grant_f = !r_last_f;
            end else if (io_bus.d_req) begin
               w_grant_d = 1'b1;
            end else if (io_bus.f_req) begin
               w_grant_f = 1'b1;
            end
`else
            if (io_bus.d_req)      w_grant_d = 1'b1;
            else if (io_bus.f_req) w_grant_f = 1'b1;
`endif
            if (w_grant_d)      w_next = S_DATA;
            else if (w_grant_f) w_next = S_FETCH;
         end
         S_FETCH, S_DATA: begin
            if (w_done || w_timeout) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Memory strobes, acks and stall from state and latched operands
   always_comb begin
      w_m_read  = 1'b0;
      w_m_write = 1'b0;
      w_m_addr  = '0;
      w_m_wdata = '0;
      w_f_ack   = 1'b0;
      w_d_ack   = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_m_read = 1'b1;
            w_m_addr = r_addr;
            w_f_ack  = w_done;
         end
         S_DATA: begin
            w_m_read  = !r_we;
            w_m_write = r_we;
            w_m_addr  = r_addr;
            w_m_wdata = r_wdata;
            w_d_ack   = w_done;
         end
         default: ;
      endcase
      w_stall = (io_bus.f_req || io_bus.d_req) && !(w_f_ack || w_d_ack);
   end

   // Operand latch, busy counter, read-data capture and err pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         r_addr    <= '0;
         r_we      <= 1'b0;
         r_wdata   <= '0;
         r_cnt     <= '0;
         r_f_rdata <= '0;
         r_d_rdata <= '0;
         r_err     <= 1'b0;
      end else begin
         r_err <= w_timeout;
         if (w_grant_d) begin
            r_addr  <= io_bus.d_addr;
            r_we    <= io_bus.d_we;
            r_wdata <= io_bus.d_wdata;
            r_cnt   <= '0;
         end else if (w_grant_f) begin
            r_addr  <= io_bus.f_addr;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_cnt   <= '0;
         end else if (w_active && io_bus.busy && (r_cnt != CW'(TIMEOUT))) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_f_ack)          r_f_rdata <= io_bus.m_rdata;
         if (w_d_ack && !r_we) r_d_rdata <= io_bus.m_rdata;
      end
   end

`ifdef MEM_ARB_RR_EN
   // Remember which requester won last; starts as fetch so data wins first
   always_ff @(posedge clock) begin
      if (reset)          r_last_f <= 1'b1;
      else if (w_grant_d) r_last_f <= 1'b0;
      else if (w_grant_f) r_last_f <= 1'b1;
   end
`endif

   assign io_bus.m_read  = w_m_read;
   assign io_bus.m_write = w_m_write;
   assign io_bus.m_addr  = w_m_addr;
   assign io_bus.m_wdata = w_m_wdata;
   assign io_bus.f_ack   = w_f_ack;
   assign io_bus.d_ack   = w_d_ack;
   assign io_bus.f_rdata = r_f_rdata;
   assign io_bus.d_rdata = r_d_rdata;
   assign io_bus.stall   = w_stall;
   assign io_bus.err     = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter (NBITS=8, TIMEOUT=15).
// Memory model returns addr ^ 0x17 on reads.
module tb_mem_arbiter;

   typedef struct {
      bit         is_d;
      bit         we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } txn_t;

   logic clock;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   txn_t exp_q[$];
   logic [7:0] exp_f;
   logic [7:0] exp_d;
   int   d_left;
   int   f_left;

   mem_arbiter_if #(.NBITS(8)) bus ();

   mem_arbiter #(.NBITS(8), .TIMEOUT(15)) dut (
      .clock  (clock),
      .reset  (reset),
      .io_bus (bus)
   );

   assign bus.m_rdata = bus.m_addr ^ 8'h17;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one granted transaction: grant edge, nbusy busy cycles, ack cycle, capture edge
   task automatic complete_one(input int nbusy);
      txn_t e;
      tick();
      if (exp_q.size() == 0) begin
         check("sb_underflow", 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      for (int i = 0; i < nbusy; i++) begin
         bus.busy = 1'b1;
         #1;
         check("busy_m_read",  {31'd0, bus.m_read},  {31'd0, !(e.is_d && e.we)});
         check("busy_m_write", {31'd0, bus.m_write}, {31'd0, e.is_d && e.we});
         check("busy_m_addr",  {24'd0, bus.m_addr},  {24'd0, e.addr});
         check("busy_acks",    {30'd0, bus.f_ack, bus.d_ack}, 32'd0);
         check("busy_stall",   {31'd0, bus.stall}, 32'd1);
         tick();
      end
      bus.busy = 1'b0;
      #1;
      check("f_ack",   {31'd0, bus.f_ack},   {31'd0, !e.is_d});
      check("d_ack",   {31'd0, bus.d_ack},   {31'd0, e.is_d});
      check("m_read",  {31'd0, bus.m_read},  {31'd0, !(e.is_d && e.we)});
      check("m_write", {31'd0, bus.m_write}, {31'd0, e.is_d && e.we});
      check("m_addr",  {24'd0, bus.m_addr},  {24'd0, e.addr});
      if (e.is_d) check("m_wdata", {24'd0, bus.m_wdata}, {24'd0, e.wdata});
      check("ack_stall", {31'd0, bus.stall}, 32'd0);
      if (!e.is_d)    exp_f = e.addr ^ 8'h17;
      else if (!e.we) exp_d = e.addr ^ 8'h17;
      if (e.is_d) begin
         d_left--;
         if (d_left == 0) bus.d_req = 1'b0;
      end else begin
         f_left--;
         if (f_left == 0) bus.f_req = 1'b0;
      end
      tick();
      check("f_rdata", {24'd0, bus.f_rdata}, {24'd0, exp_f});
      check("d_rdata", {24'd0, bus.d_rdata}, {24'd0, exp_d});
      check("err_none", {31'd0, bus.err}, 32'd0);
   endtask

   initial begin
      reset       = 1'b1;
      bus.f_req   = 1'b0;
      bus.f_addr  = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      bus.busy    = 1'b0;
      exp_f       = '0;
      exp_d       = '0;
      d_left      = 0;
      f_left      = 0;

      // reset state
      tick();
      tick();
      check("rst_m_read",  {31'd0, bus.m_read},  32'd0);
      check("rst_m_write", {31'd0, bus.m_write}, 32'd0);
      check("rst_m_addr",  {24'd0, bus.m_addr},  32'd0);
      check("rst_m_wdata", {24'd0, bus.m_wdata}, 32'd0);
      check("rst_acks",    {30'd0, bus.f_ack, bus.d_ack}, 32'd0);
      check("rst_f_rdata", {24'd0, bus.f_rdata}, 32'd0);
      check("rst_d_rdata", {24'd0, bus.d_rdata}, 32'd0);
      check("rst_err",     {31'd0, bus.err},     32'd0);
      reset = 1'b0;
      tick();
      check("idle_stall0", {31'd0, bus.stall}, 32'd0);

      // single fetch, zero wait
      bus.f_req  = 1'b1;
      bus.f_addr = 8'h04;
      f_left     = 1;
      exp_q.push_back('{is_d: 1'b0, we: 1'b0, addr: 8'h04, wdata: 8'h00});
      #1;
      check("idle_stall1", {31'd0, bus.stall}, 32'd1);
      check("idle_no_ack", {30'd0, bus.f_ack, bus.d_ack}, 32'd0);
      complete_one(0);
      check("fetch_0x13", {24'd0, bus.f_rdata}, 32'h13);

      // data write with three busy cycles
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 8'h20;
      bus.d_wdata = 8'hAA;
      d_left      = 1;
      exp_q.push_back('{is_d: 1'b1, we: 1'b1, addr: 8'h20, wdata: 8'hAA});
      complete_one(3);
      check("write_d_rdata_kept", {24'd0, bus.d_rdata}, 32'h00);

      // fetch with busy stuck: timeout after 15 busy cycles
      bus.f_req  = 1'b1;
      bus.f_addr = 8'h55;
      tick();
      bus.busy = 1'b1;
      for (int i = 0; i < 15; i++) begin
         #1;
         check("to_m_read", {31'd0, bus.m_read}, 32'd1);
         check("to_no_ack", {30'd0, bus.f_ack, bus.d_ack}, 32'd0);
         check("to_no_err", {31'd0, bus.err}, 32'd0);
         tick();
      end
      #1;
      check("to_err",      {31'd0, bus.err},    32'd1);
      check("to_idle",     {31'd0, bus.m_read}, 32'd0);
      check("to_no_f_ack", {31'd0, bus.f_ack},  32'd0);
      bus.f_req = 1'b0;
      bus.busy  = 1'b0;
      tick();
      check("to_err_pulse", {31'd0, bus.err},     32'd0);
      check("to_f_rdata",   {24'd0, bus.f_rdata}, {24'd0, exp_f});

      // reset during a busy data write
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 8'h66;
      bus.d_wdata = 8'h5A;
      tick();
      bus.busy = 1'b1;
      #1;
      check("mid_m_write", {31'd0, bus.m_write}, 32'd1);
      tick();
      check("mid_m_write2", {31'd0, bus.m_write}, 32'd1);
      reset     = 1'b1;
      bus.d_req = 1'b0;
      #1;
      check("mid_no_ack", {31'd0, bus.d_ack}, 32'd0);
      tick();
      check("mrst_m_write", {31'd0, bus.m_write}, 32'd0);
      check("mrst_m_read",  {31'd0, bus.m_read},  32'd0);
      check("mrst_m_addr",  {24'd0, bus.m_addr},  32'd0);
      check("mrst_m_wdata", {24'd0, bus.m_wdata}, 32'd0);
      check("mrst_d_ack",   {31'd0, bus.d_ack},   32'd0);
      check("mrst_f_rdata", {24'd0, bus.f_rdata}, 32'd0);
      check("mrst_err",     {31'd0, bus.err},     32'd0);
      exp_f    = '0;
      exp_d    = '0;
      reset    = 1'b0;
      bus.busy = 1'b0;
      tick();

      // contention: both requesters want two transactions each
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 8'h31;
      bus.d_wdata = 8'h00;
      bus.f_req   = 1'b1;
      bus.f_addr  = 8'h42;
      d_left      = 2;
      f_left      = 2;
`ifdef MEM_ARB_RR_EN
      exp_q.push_back('{is_d: 1'b1, we: 1'b0, addr: 8'h31, wdata: 8'h00});
      exp_q.push_back('{is_d: 1'b0, we: 1'b0, addr: 8'h42, wdata: 8'h00});
      exp_q.push_back('{is_d: 1'b1, we: 1'b0, addr: 8'h31, wdata: 8'h00});
      exp_q.push_back('{is_d: 1'b0, we: 1'b0, addr: 8'h42, wdata: 8'h00});
`else
      exp_q.push_back('{is_d: 1'b1, we: 1'b0, addr: 8'h31, wdata: 8'h00});
      exp_q.push_back('{is_d: 1'b1, we: 1'b0, addr: 8'h31, wdata: 8'h00});
      exp_q.push_back('{is_d: 1'b0, we: 1'b0, addr: 8'h42, wdata: 8'h00});
      exp_q.push_back('{is_d: 1'b0, we: 1'b0, addr: 8'h42, wdata: 8'h00});
`endif
      complete_one(0);
      complete_one(1);
      complete_one(0);
      complete_one(2);
      check("sb_drained", exp_q.size(), 32'd0);
      check("end_stall",  {31'd0, bus.stall}, 32'd0);
      check("end_idle",   {30'd0, bus.m_read, bus.m_write}, 32'd0);
      check("end_d_rdata", {24'd0, bus.d_rdata}, 32'h26);
      check("end_f_rdata", {24'd0, bus.f_rdata}, 32'h55);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NBITS, default 8, address/data width.
REQ-002 SHALL have parameter TIMEOUT, default 15, max cycles busy may stay high for one transaction.
REQ-003 SHALL have ports: clock in 1 clock; reset in 1 reset, synchronous, active-high.
REQ-004 SHALL have fetch port: f_req in 1 fetch request; f_addr in NBITS fetch address; f_ack out 1 fetch complete; f_rdata out NBITS last fetched word.
REQ-005 SHALL have data port: d_req in 1 data request; d_we in 1 write (1) or read (0); d_addr in NBITS; d_wdata in NBITS; d_ack out 1 data complete; d_rdata out NBITS last read word.
REQ-006 SHALL have memory port: m_read out 1; m_write out 1; m_addr out NBITS; m_wdata out NBITS; m_rdata in NBITS; busy in 1 memory not ready.
REQ-007 SHALL have status: stall out 1 a request is pending and not yet acked; err out 1 timeout pulse.

Function
REQ-008 SHALL implement FSM states IDLE, FETCH, DATA.
REQ-009 IDLE: d_req=1 -> DATA; else f_req=1 -> FETCH; else stay (fixed priority, data wins).
REQ-010 SHALL latch address, d_we, d_wdata into registers on the IDLE->grant edge; memory outputs come from those registers only.
REQ-011 FETCH: m_read=1, m_write=0, m_addr=latched f_addr; DATA: m_read=!we, m_write=we, m_addr/m_wdata latched; IDLE: m_read=m_write=0, m_addr=m_wdata=0.
REQ-012 Completion = cycle in FETCH/DATA with busy=0; that cycle f_ack/d_ack SHALL be 1 combinationally for exactly one cycle and FSM returns to IDLE on next edge.
REQ-013 On fetch completion f_rdata SHALL capture m_rdata; on data read completion d_rdata SHALL capture m_rdata; both hold until next capture; data write leaves d_rdata unchanged.
REQ-014 Minimum latency: req high in IDLE at cycle t, busy=0 -> ack at t+1; next grant earliest t+2.
REQ-015 Requester SHALL hold req and operands until ack; req dropped mid-transaction does not abort, ack still issued.
REQ-016 Requests arriving during a grant SHALL wait; no transaction is lost or duplicated while req is held.
REQ-017 stall SHALL equal (f_req or d_req) and not (f_ack or d_ack).
REQ-018 A 4-bit-or-wider counter SHALL clear on grant and increment each FETCH/DATA cycle with busy=1; on reaching TIMEOUT, err=1 for one cycle, no ack, FSM -> IDLE.
REQ-019 Never m_read and m_write simultaneously; never both acks in the same cycle.

Reset
REQ-020 Reset SHALL force IDLE, m_read=m_write=0, m_addr=m_wdata=0, f_ack=d_ack=0, f_rdata=d_rdata=0, err=0, counter=0.
REQ-021 Reset mid-transaction SHALL abandon it without ack; memory strobes drop in the cycle after the reset edge.

Configuration
REQ-022 Macro MEM_ARB_RR_EN defined: IDLE with both requests grants the port not granted last (last-grant flag reset to FETCH, so first contention grants DATA).
REQ-023 Macro MEM_ARB_RR_EN undefined: fixed data-over-fetch priority per REQ-009, no last-grant flag.

Verification
REQ-024 f_req=1, f_addr=0x04, busy=0, m_rdata=0x13 -> m_read=1, m_addr=0x04 next cycle, f_ack=1 same cycle, f_rdata=0x13 after.
REQ-025 d_req=1, d_we=1, d_addr=0x20, d_wdata=0xAA, busy=1 for 3 cycles -> m_write=1 held 4 cycles, d_ack on 4th, d_rdata unchanged.
REQ-026 f_req and d_req both held, busy=0 -> fixed: DATA then FETCH; RR_EN: DATA, FETCH, DATA, FETCH alternating.
REQ-027 busy stuck at 1 on fetch, TIMEOUT=15 -> err pulse after 15 busy cycles, no f_ack, FSM IDLE.
REQ-028 reset asserted during DATA with busy=1 -> next cycle m_write=0, no d_ack, outputs at reset values.
